// File: rtl/result_display_mux.sv
// Captures a 9-bit add/sub result, converts it to sign + 3 BCD digits with a
// sequential double-dabble, and scans it onto a 4-digit common-anode display.
module result_display_mux #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] resultado,
  input  logic       sel,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t         state_reg, state_next;
  logic [8:0]     shift_reg;
  logic [11:0]    bcd_reg;
  logic [3:0]     iter_reg;
  logic           neg_reg;
  logic [3:0]     hund_reg, tens_reg, units_reg;
  logic           disp_neg_reg;
  logic           done_reg;
  logic [CW-1:0]  refresh_reg;
  logic [1:0]     digit_reg;

  logic [11:0]    bcd_adj;
  logic [20:0]    shifted;
  logic [8:0]     magnitude;
  logic           negative;

  // Only a subtraction result with the sign bit set is treated as negative.
  assign negative  = sel & resultado[8];
  assign magnitude = negative ? (~resultado + 9'd1) : resultado;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  (bcd_reg[gi*4 +: 4] + 4'd3) : bcd_reg[gi*4 +: 4];
    end
  endgenerate

  assign shifted = {bcd_adj[10:0], shift_reg, 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = CONV;
      CONV:    if (iter_reg == 4'd8) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg    <= '0;
      bcd_reg      <= '0;
      iter_reg     <= '0;
      neg_reg      <= 1'b0;
      hund_reg     <= '0;
      tens_reg     <= '0;
      units_reg    <= '0;
      disp_neg_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= (state_reg == COMMIT);
      case (state_reg)
        IDLE: begin
          if (start) begin
            shift_reg <= magnitude;
            neg_reg   <= negative;
            bcd_reg   <= '0;
            iter_reg  <= '0;
          end
        end
        CONV: begin
          bcd_reg   <= shifted[20:9];
          shift_reg <= shifted[8:0];
          iter_reg  <= iter_reg + 4'd1;
        end
        COMMIT: begin
          hund_reg     <= bcd_reg[11:8];
          tens_reg     <= bcd_reg[7:4];
          units_reg    <= bcd_reg[3:0];
          disp_neg_reg <= neg_reg;
        end
        default: ;
      endcase
    end
  end

  // Free-running scan, never disturbed by conversions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_reg <= '0;
      digit_reg   <= '0;
    end else if (refresh_reg == CW'(REFRESH_DIV - 1)) begin
      refresh_reg <= '0;
      digit_reg   <= digit_reg + 2'd1;
    end else begin
      refresh_reg <= refresh_reg + 1'b1;
    end
  end

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction

  // Leading zeros are blanked; the units digit is always shown.
  always_comb begin
    an  = ~(4'b0001 << digit_reg);
    seg = SEG_BLANK;
    case (digit_reg)
      2'd3: seg = disp_neg_reg ? SEG_MINUS : SEG_BLANK;
      2'd2: seg = (hund_reg != 4'd0) ? seg_of(hund_reg) : SEG_BLANK;
      2'd1: seg = ((hund_reg != 4'd0) || (tens_reg != 4'd0)) ? seg_of(tens_reg) : SEG_BLANK;
      default: seg = seg_of(units_reg);
    endcase
  end

  assign busy = (state_reg != IDLE);
  assign done = done_reg;

endmodule

// File: doc/result_display_mux.md
# result_display_mux

Downstream stage of the 8-bit add/subtract unit. It captures the unit's 9-bit `resultado` together with its `Sel` mode bit, converts the value to sign plus three BCD digits with a sequential double-dabble engine, and drives a time-multiplexed 4-digit common-anode 7-segment display. It sits between the arithmetic stage and the board's display pins.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit stays lit; must be ≥ 2.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `resultado`  in  9  result from the add/subtract stage.
- `sel`  in  1  mode of that result:
  - 0 = sum, unsigned, 0..510.
  - 1 = subtraction, two's complement, −255..255.
- `start`  in  1  capture request; sampled on each rising edge; ignored while `busy`.
- `busy`  out  1  conversion in progress.
- `done`  out  1  one-cycle pulse when new digits are committed to the display.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `an`  out  4  digit anodes, active-low; `an[3]` is the leftmost (sign) digit, `an[0]` the units digit.

## Operation
- Capture:
  - `start`=1 at an edge while IDLE latches `resultado` and `sel`.
  - Magnitude and sign are derived at capture:
    - `sel`=0: magnitude = `resultado` (unsigned), negative = 0.
    - `sel`=1 and `resultado[8]`=1: magnitude = (~`resultado` + 1) truncated to 9 bits, negative = 1.
    - `sel`=1 and `resultado[8]`=0: magnitude = `resultado`, negative = 0.
  - Magnitude never exceeds 510, so it fits 9 bits and 3 BCD digits.
- FSM states: IDLE, CONV, COMMIT.
  - IDLE → CONV on accepted `start`. The capture edge loads a 9-bit shift register, clears the 12-bit BCD accumulator and clears the iteration counter.
  - CONV runs 9 iterations, one per cycle. Each iteration:
    - adds 3 to every BCD nibble that is ≥ 5;
    - then shifts {bcd, shift register} left by 1.
  - CONV → COMMIT after the 9th iteration.
  - COMMIT → IDLE unconditionally. It copies hundreds, tens, units and negative into the display registers and pulses `done`.
- `busy` = (state != IDLE). A `start` while busy is dropped and is not queued.
- The display registers change only in COMMIT. The display holds the last committed value indefinitely.
- Digit content per position:
  - `an[3]`: '-' (7'b0111111) if negative, else blank (7'b1111111).
  - `an[2]`: hundreds digit; blank if hundreds = 0.
  - `an[1]`: tens digit; blank if hundreds = 0 and tens = 0.
  - `an[0]`: units digit, always shown.
- Segment patterns for 0..9, active-low: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
- Multiplexing:
  - The refresh counter counts 0..REFRESH_DIV−1 and wraps to 0.
  - On wrap, the digit index advances 0→1→2→3→0.
  - Index i drives `an` with only bit i low. `seg` is the pattern of digit i in the same cycle.
- Refresh runs continuously and independently of conversion. It is never stalled or restarted by `start`.

## Timing
- Reset (asynchronous, immediate, including mid-conversion):
  - FSM returns to IDLE; `busy`=0, `done`=0.
  - Display registers = 0, positive.
  - Refresh counter = 0, digit index = 0.
  - Outputs: `an`=4'b1110, `seg`=7'b1000000 (shows "   0").
  - An interrupted conversion is discarded; the previous display value is not retained.
- Latency, with `start` accepted at edge k:
  - `busy`=1 from edge k to edge k+10.
  - CONV iterations occur at edges k+1..k+9.
  - COMMIT occurs at edge k+10: display registers update and `done`=1 for exactly one cycle.
  - `busy`=0 after edge k+10. The next `start` can be accepted at edge k+11.
- All outputs are registered or decoded from registers only. Nothing depends combinationally on `resultado`, `sel` or `start`.
- A digit change in COMMIT that coincides with a refresh wrap is legal. The newly selected digit shows the new value in the same cycle.

## Test plan
- Reset, then release with REFRESH_DIV=4 → `an` sequence 1110,1101,1011,0111,1110, each held 4 cycles. `seg` = 1000000 on `an[0]` and 1111111 on the others. `busy`=`done`=0.
- `sel`=0, `resultado`=9'h100, `start` pulse at edge k → `done` at edge k+10 only. Display reads " 256":
  - `an[2]` → 0100100
  - `an[1]` → 0010010
  - `an[0]` → 0000010
- `sel`=1, `resultado`=9'b111111110 → display "-  2". `an[3]` → 0111111, `an[2]`/`an[1]` blank, `an[0]` → 0100100.
- `sel`=1, `resultado`=9'b100000001 → "-255". Then `sel`=0, `resultado`=9'h1FE → " 510".
  - A second `start` with 9'h005 issued at edge k+4 is ignored; the display stays " 510".
  - `sel`=0, `resultado`=9'h000 → "   0".
- `rst_n` asserted low at edge k+5 of a conversion of 9'h0FF (`sel`=0) → all outputs take reset values immediately with no clock. After release, the display shows "   0" and no `done` pulse occurs.
